// File: rtl/axi_pkg.sv
// Shared AXI4 constants and FSM state encodings for the cache AXI driver and the memory responder.
package axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/mem_bytewise.sv
// Word array with one byte-enabled write port and one registered read port.
// No reset: contents survive reset, and the array maps onto block RAM.
module mem_bytewise #(
    parameter int WORDS = 1024,
    parameter int DW    = 64,
    parameter int IW    = $clog2(WORDS)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [IW-1:0]   waddr_i,
    input  logic [DW/8-1:0] wstrb_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic            re_i,
    input  logic [IW-1:0]   raddr_i,
    output logic [DW-1:0]   rdata_o
);

    logic [DW-1:0] mem_q [WORDS];
    logic [DW-1:0] rdata_q;

    // Byte-masked write; lanes with a clear strobe keep their old contents
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DW/8; b++) begin
                if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    // Registered read; a same-edge write to the word is not forwarded (old data returned)
    always_ff @(posedge clk_i) begin
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate backed by an on-chip word array. Independent write (AW/W/B)
// and read (AR/R) FSMs with their burst address generators.
module axi_mem_responder
    import axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MEM_WORDS      = 1024
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESETN,
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [7:0]                  S_AXI_AWLEN,
    input  logic [2:0]                  S_AXI_AWSIZE,
    input  logic [1:0]                  S_AXI_AWBURST,
    input  logic                        S_AXI_AWVALID,
    output logic                        S_AXI_AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                        S_AXI_WLAST,
    input  logic                        S_AXI_WVALID,
    output logic                        S_AXI_WREADY,
    output logic [AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                  S_AXI_BRESP,
    output logic                        S_AXI_BVALID,
    input  logic                        S_AXI_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [7:0]                  S_AXI_ARLEN,
    input  logic [2:0]                  S_AXI_ARSIZE,
    input  logic [1:0]                  S_AXI_ARBURST,
    input  logic                        S_AXI_ARVALID,
    output logic                        S_AXI_ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [1:0]                  S_AXI_RRESP,
    output logic                        S_AXI_RLAST,
    output logic                        S_AXI_RVALID,
    input  logic                        S_AXI_RREADY
);

    localparam int AW   = AXI_ADDR_WIDTH;
    localparam int DW   = AXI_DATA_WIDTH;
    localparam int IDW  = AXI_ID_WIDTH;
    localparam int BPB  = DW/8;
    localparam int OFFS = $clog2(BPB);
    localparam int IW   = $clog2(MEM_WORDS);
    localparam logic [2:0]    BEAT_SIZE  = 3'(OFFS);
    localparam logic [AW-1:0] ADDR_STEP  = AW'(BPB);
    localparam logic [AW-1:0] WORD_LIMIT = AW'(MEM_WORDS);

    // Only full-width FIXED/INCR bursts touch the array
    function automatic logic req_bad(input logic [2:0] size, input logic [1:0] burst);
        return (size != BEAT_SIZE) || !((burst == AXI_BURST_FIXED) || (burst == AXI_BURST_INCR));
    endfunction

    function automatic logic in_range(input logic [AW-1:0] a);
        return (a >> OFFS) < WORD_LIMIT;
    endfunction

    logic            up_q;
    wr_state_t       wr_q, wr_d;
    logic [AW-1:0]   waddr_q, waddr_d, wnext;
    logic [IDW-1:0]  wid_q, wid_d;
    logic [7:0]      wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [1:0]      wburst_q, wburst_d;
    logic            wbad_q, wbad_d, werr_q, werr_d;
    rd_state_t       rd_q, rd_d;
    logic [AW-1:0]   raddr_q, raddr_d, rnext, rsel_addr;
    logic [IDW-1:0]  rid_q, rid_d;
    logic [7:0]      rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [1:0]      rburst_q, rburst_d;
    logic            rbad_q, rbad_d, rberr_q, rberr_d;
    logic            mem_we, mem_re;
    logic [DW-1:0]   mem_rdata;

    assign wnext = (wburst_q == AXI_BURST_INCR) ? waddr_q + ADDR_STEP : waddr_q;
    assign rnext = (rburst_q == AXI_BURST_INCR) ? raddr_q + ADDR_STEP : raddr_q;

    // Holds both READYs low while in reset and for the first edge after it
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) up_q <= 1'b0;
        else                up_q <= 1'b1;
    end

    // Write-path state registers
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_q <= W_IDLE; waddr_q <= '0; wid_q <= '0; wlen_q <= '0;
            wcnt_q <= '0; wburst_q <= '0; wbad_q <= 1'b0; werr_q <= 1'b0;
        end else begin
            wr_q <= wr_d; waddr_q <= waddr_d; wid_q <= wid_d; wlen_q <= wlen_d;
            wcnt_q <= wcnt_d; wburst_q <= wburst_d; wbad_q <= wbad_d; werr_q <= werr_d;
        end
    end

    // Write FSM: accept AW, absorb W beats until WLAST, then hold B until BREADY
    always_comb begin
        wr_d = wr_q; waddr_d = waddr_q; wid_d = wid_q; wlen_d = wlen_q;
        wcnt_d = wcnt_q; wburst_d = wburst_q; wbad_d = wbad_q; werr_d = werr_q;
        mem_we = 1'b0;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        S_AXI_BRESP   = AXI_RESP_OKAY;
        S_AXI_BID     = wid_q;
        case (wr_q)
            W_IDLE: begin
                S_AXI_AWREADY = up_q;
                if (up_q && S_AXI_AWVALID) begin
                    waddr_d  = S_AXI_AWADDR;
                    wid_d    = S_AXI_AWID;
                    wlen_d   = S_AXI_AWLEN;
                    wburst_d = S_AXI_AWBURST;
                    wcnt_d   = '0;
                    wbad_d   = req_bad(S_AXI_AWSIZE, S_AXI_AWBURST);
                    werr_d   = wbad_d;
                    wr_d     = W_DATA;
                end
            end
            W_DATA: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID) begin
                    if (!in_range(waddr_q)) werr_d = 1'b1;
                    else if (!wbad_q)       mem_we = 1'b1;
                    if (S_AXI_WLAST != (wcnt_q == wlen_q)) werr_d = 1'b1;
                    waddr_d = wnext;
                    wcnt_d  = wcnt_q + 8'd1;
                    if (S_AXI_WLAST) wr_d = W_RESP;
                end
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                S_AXI_BRESP  = werr_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                if (S_AXI_BREADY) wr_d = W_IDLE;
            end
            default: wr_d = W_IDLE;
        endcase
    end

    // Read-path state registers
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_q <= R_IDLE; raddr_q <= '0; rid_q <= '0; rlen_q <= '0;
            rcnt_q <= '0; rburst_q <= '0; rbad_q <= 1'b0; rberr_q <= 1'b0;
        end else begin
            rd_q <= rd_d; raddr_q <= raddr_d; rid_q <= rid_d; rlen_q <= rlen_d;
            rcnt_q <= rcnt_d; rburst_q <= rburst_d; rbad_q <= rbad_d; rberr_q <= rberr_d;
        end
    end

    // Read FSM: each handshake (AR or R) launches the array read for the next beat
    always_comb begin
        rd_d = rd_q; raddr_d = raddr_q; rid_d = rid_q; rlen_d = rlen_q;
        rcnt_d = rcnt_q; rburst_d = rburst_q; rbad_d = rbad_q; rberr_d = rberr_q;
        rsel_addr = raddr_q;
        mem_re    = 1'b0;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        S_AXI_RLAST   = 1'b0;
        S_AXI_RRESP   = AXI_RESP_OKAY;
        S_AXI_RDATA   = '0;
        S_AXI_RID     = rid_q;
        case (rd_q)
            R_IDLE: begin
                S_AXI_ARREADY = up_q;
                if (up_q && S_AXI_ARVALID) begin
                    rsel_addr = S_AXI_ARADDR;
                    mem_re    = 1'b1;
                    raddr_d   = S_AXI_ARADDR;
                    rid_d     = S_AXI_ARID;
                    rlen_d    = S_AXI_ARLEN;
                    rburst_d  = S_AXI_ARBURST;
                    rcnt_d    = '0;
                    rbad_d    = req_bad(S_AXI_ARSIZE, S_AXI_ARBURST);
                    rberr_d   = rbad_d || !in_range(S_AXI_ARADDR);
                    rd_d      = R_DATA;
                end
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                S_AXI_RLAST  = (rcnt_q == rlen_q);
                S_AXI_RRESP  = rberr_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                S_AXI_RDATA  = rberr_q ? '0 : mem_rdata;
                if (S_AXI_RREADY) begin
                    if (rcnt_q == rlen_q) begin
                        rd_d = R_IDLE;
                    end else begin
                        rsel_addr = rnext;
                        mem_re    = 1'b1;
                        raddr_d   = rnext;
                        rcnt_d    = rcnt_q + 8'd1;
                        rberr_d   = rbad_q || !in_range(rnext);
                    end
                end
            end
            default: rd_d = R_IDLE;
        endcase
    end

    mem_bytewise #(
        .WORDS (MEM_WORDS),
        .DW    (DW),
        .IW    (IW)
    ) u_mem (
        .clk_i   (S_AXI_ACLK),
        .we_i    (mem_we),
        .waddr_i (IW'(waddr_q >> OFFS)),
        .wstrb_i (S_AXI_WSTRB),
        .wdata_i (S_AXI_WDATA),
        .re_i    (mem_re),
        .raddr_i (IW'(rsel_addr >> OFFS)),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: single and burst writes/reads,
// back-pressure on B and R, strobes, range/size/burst errors, and mid-burst reset.
module tb_axi_mem_responder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] awaddr = '0;
    logic [3:0]  awid = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0, awready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wlast = 1'b0, wvalid = 1'b0, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready = 1'b0;
    logic [31:0] araddr = '0;
    logic [3:0]  arid = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0, arready;
    logic [63:0] rdata;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axi_mem_responder dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWID(awid), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
        .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARID(arid), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
        .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RID(rid), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
        int n = 0;
        @(negedge clk);
        awaddr = a; awid = id; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        chk("aw_wait", 64'(n), 64'd0);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [63:0] d, input logic [7:0] s, input logic l);
        int n = 0;
        @(negedge clk);
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        while (!wready && n < 20) begin @(negedge clk); n++; end
        chk("w_wait", 64'(n), 64'd0);
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic do_b(input logic [3:0] id, input logic [1:0] resp, input int stall, input string tag);
        int n = 0;
        bready = 1'b0;
        @(negedge clk);
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_blat"}, 64'(n), 64'd0);
        chk({tag, "_bid"}, 64'(bid), 64'(id));
        chk({tag, "_bresp"}, 64'(bresp), 64'(resp));
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk({tag, "_bhold"}, 64'({bvalid, bid, bresp}), 64'({1'b1, id, resp}));
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        chk({tag, "_bdrop"}, 64'(bvalid), 64'd0);
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
        int n = 0;
        @(negedge clk);
        araddr = a; arid = id; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        chk("ar_wait", 64'(n), 64'd0);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    // Expects the beat on the very next sample (no bubble); stall holds RREADY low first
    task automatic do_r(input logic [63:0] d, input logic [1:0] resp, input logic l,
                        input logic [3:0] id, input int stall, input string tag);
        int n = 0;
        if (stall > 0) rready = 1'b0;
        @(negedge clk);
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_rlat"}, 64'(n), 64'd0);
        chk({tag, "_rdata"}, rdata, d);
        chk({tag, "_rctl"}, 64'({rlast, rresp, rid}), 64'({l, resp, id}));
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk({tag, "_rhold_d"}, rdata, d);
            chk({tag, "_rhold_c"}, 64'({rvalid, rlast, rresp, rid}), 64'({1'b1, l, resp, id}));
        end
        rready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic r_end(input string tag);
        @(negedge clk);
        chk({tag, "_rend"}, 64'({rvalid, arready}), 64'({1'b0, 1'b1}));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        int st[4];
        st = '{2, 0, 5, 1};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'({awready, wready, arready}), 64'd0);
        chk("rst_valid", 64'({bvalid, rvalid, rlast}), 64'd0);
        chk("rst_resp_id", 64'({bresp, rresp, bid, rid}), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Single-beat write, B one cycle after W, then read back
        do_aw(32'h40, 4'h5, 8'd0, 3'd3, 2'b01);
        do_w(64'h1122334455667788, 8'hFF, 1'b1);
        do_b(4'h5, 2'b00, 0, "t1");
        rready = 1'b1;
        do_ar(32'h40, 4'h2, 8'd0, 3'd3, 2'b01);
        do_r(64'h1122334455667788, 2'b00, 1'b1, 4'h2, 0, "t1r");
        r_end("t1r");

        // 4-beat INCR write of 1..4 at 0x40, back-to-back read
        do_aw(32'h40, 4'h3, 8'd3, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++) do_w(64'(i + 1), 8'hFF, i == 3);
        do_b(4'h3, 2'b00, 0, "t2");
        rready = 1'b1;
        do_ar(32'h40, 4'h9, 8'd3, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++) do_r(64'(i + 1), 2'b00, i == 3, 4'h9, 0, "t2r");
        r_end("t2r");

        // Back-pressure on B and R
        do_aw(32'h100, 4'h7, 8'd3, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++) do_w(64'hA5A5_0000 + 64'(i), 8'hFF, i == 3);
        do_b(4'h7, 2'b00, 3, "t3");
        do_ar(32'h100, 4'hC, 8'd3, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++) do_r(64'hA5A5_0000 + 64'(i), 2'b00, i == 3, 4'hC, st[i], "t3r");
        r_end("t3r");

        // Partial strobe over all-ones
        do_aw(32'h200, 4'h1, 8'd0, 3'd3, 2'b01);
        do_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
        do_b(4'h1, 2'b00, 0, "t4a");
        do_aw(32'h200, 4'h1, 8'd0, 3'd3, 2'b01);
        do_w(64'h0, 8'h0F, 1'b1);
        do_b(4'h1, 2'b00, 0, "t4b");
        do_ar(32'h200, 4'h1, 8'd0, 3'd3, 2'b01);
        do_r(64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1, 4'h1, 0, "t4r");

        // Last word in range, then one past the end
        do_aw(32'h1FF8, 4'h2, 8'd0, 3'd3, 2'b01);
        do_w(64'hCAFE_F00D, 8'hFF, 1'b1);
        do_b(4'h2, 2'b00, 0, "t5a");
        do_ar(32'h1FF8, 4'h4, 8'd1, 3'd3, 2'b01);
        do_r(64'hCAFE_F00D, 2'b00, 1'b0, 4'h4, 0, "t5r1");
        do_r(64'h0, 2'b10, 1'b1, 4'h4, 0, "t5r2");
        r_end("t5r");
        do_aw(32'h2000, 4'h6, 8'd0, 3'd3, 2'b01);
        do_w(64'h1234, 8'hFF, 1'b1);
        do_b(4'h6, 2'b10, 0, "t5oor");
        // Narrow write is refused and leaves the word alone
        do_aw(32'h40, 4'h8, 8'd0, 3'd2, 2'b01);
        do_w(64'hDEAD, 8'hFF, 1'b1);
        do_b(4'h8, 2'b10, 0, "t5size");
        do_ar(32'h40, 4'h8, 8'd0, 3'd3, 2'b01);
        do_r(64'd1, 2'b00, 1'b1, 4'h8, 0, "t5keep");
        // WRAP read: every beat SLVERR
        do_ar(32'h48, 4'hA, 8'd1, 3'd3, 2'b10);
        do_r(64'h0, 2'b10, 1'b0, 4'hA, 0, "t5wrap1");
        do_r(64'h0, 2'b10, 1'b1, 4'hA, 0, "t5wrap2");
        // WLAST one beat early
        do_aw(32'h60, 4'hB, 8'd1, 3'd3, 2'b01);
        do_w(64'h55, 8'hFF, 1'b1);
        do_b(4'hB, 2'b10, 0, "t5wlast");

        // Reset in the middle of a write and an 8-beat read
        do_aw(32'h300, 4'h1, 8'd3, 3'd3, 2'b01);
        do_w(64'h77, 8'hFF, 1'b0);
        do_ar(32'h40, 4'h4, 8'd7, 3'd3, 2'b01);
        do_r(64'd1, 2'b00, 1'b0, 4'h4, 0, "t6r1");
        rready = 1'b0;
        @(negedge clk);
        chk("t6_mid_rdata", rdata, 64'd2);
        chk("t6_mid_ctl", 64'({rvalid, wready}), 64'({1'b1, 1'b1}));
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", 64'({rvalid, bvalid, wready, awready, arready}), 64'd0);
        chk("t6_rst_rdata", rdata, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        do_aw(32'h300, 4'h6, 8'd0, 3'd3, 2'b01);
        do_w(64'h99, 8'hFF, 1'b1);
        do_b(4'h6, 2'b00, 0, "t6b");
        rready = 1'b1;
        do_ar(32'h300, 4'h3, 8'd0, 3'd3, 2'b01);
        do_r(64'h99, 2'b00, 1'b1, 4'h3, 0, "t6r_new");
        do_ar(32'h48, 4'h5, 8'd0, 3'd3, 2'b01);
        do_r(64'd2, 2'b00, 1'b1, 4'h5, 0, "t6r_kept");
        r_end("t6r");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
